// File: rtl/regfile_wb_arbiter_if.sv
// Write-back request, scoreboard and register-file bus of the write-back arbiter.
// Latency 1 to regWrite; backpressure is a per-requester combinational ready.
interface regfile_wb_arbiter_if #(
    parameter int XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;

    logic            ld_valid;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic            ld_ready;

    logic            dbg_valid;
    logic [4:0]      dbg_rd;
    logic [XLEN-1:0] dbg_data;
    logic            dbg_ready;

    logic            ld_issue;
    logic [4:0]      ld_issue_rd;
    logic [4:0]      hz_rs1;
    logic [4:0]      hz_rs2;
    logic            stall;

    logic            regWrite;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            sb_err;

    // Pipeline side: requesters, load issue and hazard query.
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output dbg_valid, dbg_rd, dbg_data,
        output ld_issue, ld_issue_rd, hz_rs1, hz_rs2,
        input  alu_ready, ld_ready, dbg_ready, stall,
        input  regWrite, wb_rd, wb_data, sb_err
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  dbg_valid, dbg_rd, dbg_data,
        input  ld_issue, ld_issue_rd, hz_rs1, hz_rs2,
        output alu_ready, ld_ready, dbg_ready, stall,
        output regWrite, wb_rd, wb_data, sb_err
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates ALU/load/debug onto the register-file write port and tracks pending loads for RAW stalls.
// Latency 1 grant-to-regWrite; requesters wait on a combinational ready, debug is force-granted after STARVE_LIMIT refusals.
module regfile_wb_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int XLEN         = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_wb_arbiter_if.slave  bus
);
    localparam logic [7:0] STARVE_W = 8'(STARVE_LIMIT);

    logic            rr_q, rr_d;
    logic [7:0]      dbg_wait_q, dbg_wait_d;
    logic [31:0]     pending_q, pending_d;
    logic            reg_write_q, reg_write_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic            sb_err_q, sb_err_d;

    logic            gnt_alu, gnt_ld, gnt_dbg, gnt_any;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;
    logic [31:0]     set_vec, clr_vec, pend_kept;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        gnt_dbg = 1'b0;
        if (bus.dbg_valid && dbg_wait_q == STARVE_W) begin
            gnt_dbg = 1'b1;
        end else if (bus.alu_valid && bus.ld_valid) begin
            // rr_q=1 means the ALU has the next tie.
            gnt_alu = rr_q;
            gnt_ld  = !rr_q;
        end else if (bus.alu_valid) begin
            gnt_alu = 1'b1;
        end else if (bus.ld_valid) begin
            gnt_ld = 1'b1;
        end else if (bus.dbg_valid) begin
            gnt_dbg = 1'b1;
        end
    end

    assign gnt_any       = gnt_alu | gnt_ld | gnt_dbg;
    assign bus.alu_ready = gnt_alu;
    assign bus.ld_ready  = gnt_ld;
    assign bus.dbg_ready = gnt_dbg;

    always_comb begin
        sel_rd   = bus.dbg_rd;
        sel_data = bus.dbg_data;
        if (gnt_alu) begin
            sel_rd   = bus.alu_rd;
            sel_data = bus.alu_data;
        end else if (gnt_ld) begin
            sel_rd   = bus.ld_rd;
            sel_data = bus.ld_data;
        end
    end

    always_comb begin
        reg_write_d = gnt_any && (sel_rd != 5'd0);
        wb_rd_d     = gnt_any ? sel_rd : wb_rd_q;
        wb_data_d   = gnt_any ? sel_data : wb_data_q;

        rr_d = rr_q;
        if (gnt_alu) rr_d = 1'b0;
        else if (gnt_ld) rr_d = 1'b1;

        dbg_wait_d = 8'd0;
        if (bus.dbg_valid && !gnt_dbg)
            dbg_wait_d = (dbg_wait_q == STARVE_W) ? dbg_wait_q : dbg_wait_q + 8'd1;

        clr_vec   = gnt_ld ? (32'd1 << bus.ld_rd) : 32'd0;
        set_vec   = (bus.ld_issue && bus.ld_issue_rd != 5'd0) ? (32'd1 << bus.ld_issue_rd) : 32'd0;
        pend_kept = pending_q & ~clr_vec;
        // Set after clear: a new load to the same register keeps the bit alive.
        pending_d = (pend_kept | set_vec) & ~32'd1;

        sb_err_d = sb_err_q;
        if (bus.ld_issue && bus.ld_issue_rd != 5'd0 && pend_kept[bus.ld_issue_rd])
            sb_err_d = 1'b1;
        if (gnt_ld && !pending_q[bus.ld_rd])
            sb_err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q        <= 1'b1;
            dbg_wait_q  <= 8'd0;
            pending_q   <= 32'd0;
            reg_write_q <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            sb_err_q    <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            dbg_wait_q  <= dbg_wait_d;
            pending_q   <= pending_d;
            reg_write_q <= reg_write_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            sb_err_q    <= sb_err_d;
        end
    end

    function automatic logic hazard(input logic [4:0] s, input logic [31:0] pend,
                                    input logic wv, input logic [4:0] wrd);
        return (s != 5'd0) && (pend[s] || (wv && wrd == s));
    endfunction

    assign bus.stall    = hazard(bus.hz_rs1, pending_q, reg_write_q, wb_rd_q)
                        | hazard(bus.hz_rs2, pending_q, reg_write_q, wb_rd_q);
    assign bus.regWrite = reg_write_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.sb_err   = sb_err_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (regWrite / rd / writeData) among three requesters:
  - ALU write-back
  - load-data return from the data memory
  - debug/UART host register writes
- Keeps a pending-load scoreboard and raises a read-after-write stall for the issue stage.
- Sits between the execute/memory stages and the register-file decoder.
- Its registered outputs drive the register file's write inputs directly.

Parameters:
- STARVE_LIMIT, 8: cycles a waiting debug request may be refused before it is force-granted (1..255).
- XLEN, 32: write-back data width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- alu_valid  in  1  ALU write-back request
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- alu_ready  out  1  ALU request accepted this cycle
- ld_valid  in  1  load-return write-back request
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load data
- ld_ready  out  1  load request accepted this cycle
- dbg_valid  in  1  debug write request
- dbg_rd  in  5  debug destination register
- dbg_data  in  XLEN  debug data
- dbg_ready  out  1  debug request accepted this cycle
- ld_issue  in  1  load issued to memory this cycle
- ld_issue_rd  in  5  destination register of the issued load
- hz_rs1  in  5  issue-stage source register 1
- hz_rs2  in  5  issue-stage source register 2
- stall  out  1  issue stage must hold
- regWrite  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset: on a clk edge with rst=0, all of the following clear:
  - regWrite, wb_rd, wb_data, sb_err, the 32-bit pending vector and dbg_wait all go to 0.
  - rr goes to 1, so the ALU wins the first tie.
  - Reset mid-operation drops any in-flight write-back and all pending bits.
- Handshake:
  - A transfer occurs on a cycle with valid && ready.
  - Requesters hold valid, rd and data stable until ready.
  - The ready outputs are combinational from the valids and state.
  - At most one ready is high per cycle.
  - A ready is never high without its matching valid.
- Grant priority, evaluated each cycle:
  1. If dbg_valid && dbg_wait==STARVE_LIMIT, grant debug.
  2. Else if exactly one of alu_valid / ld_valid is high, grant it.
  3. Else if both are high, round-robin: grant ld when rr==0, grant alu when rr==1.
  4. Else if only dbg_valid is high, grant debug.
- rr update: set to 0 after an ALU grant, 1 after a load grant; unchanged otherwise.
- dbg_wait:
  - Increments, saturating at STARVE_LIMIT, on each cycle with dbg_valid && !dbg_ready.
  - Clears to 0 on a debug grant or when dbg_valid=0.
- Write-back timing (latency 1):
  - A grant in cycle N gives regWrite=1, wb_rd=granted rd and wb_data=granted data during cycle N+1.
  - The register file commits at the end of N+1.
  - regWrite is high for exactly one cycle per grant.
  - With no grant, regWrite=0 and wb_rd/wb_data hold their last values.
- rd==0: the request is still accepted (ready=1), but regWrite stays 0 in N+1.
- Scoreboard (pending[31:1]; pending[0] is always 0):
  - Set: ld_issue && ld_issue_rd!=0 sets pending[ld_issue_rd].
  - Clear: a load grant clears pending[ld_rd].
  - Same register set and cleared in the same cycle: set wins, so the bit stays 1 (a new load follows the old one).
  - ld_issue to a register whose bit is already set and not cleared that cycle: sets sb_err (sticky until reset); the bit stays 1.
  - A load grant whose ld_rd bit is 0: sets sb_err.
- Stall (combinational): stall = OR over s in {hz_rs1, hz_rs2} with s!=0 of (pending[s] || (regWrite && wb_rd==s)).
  - This covers both loads still outstanding and the write-back in flight during cycle N+1.

Test Plan:
- Single requester:
  - alu_valid=1, alu_rd=5, alu_data=0x1234 for one cycle → alu_ready=1 that cycle.
  - Next cycle: regWrite=1, wb_rd=5, wb_data=0x1234.
  - Cycle after: regWrite=0.
- Round-robin fairness:
  - alu_valid and ld_valid both held high for 4 cycles after reset → grants in order alu, ld, alu, ld.
  - regWrite=1 on 4 consecutive cycles, starting one cycle after the first grant.
- Debug starvation (STARVE_LIMIT=8):
  - dbg_valid plus alu/ld continuously valid → dbg_ready=0 for 8 cycles, then dbg_ready=1 on the 9th cycle.
  - dbg_wait returns to 0 afterwards.
- Scoreboard stall:
  - ld_issue, ld_issue_rd=7; then hz_rs1=7 → stall=1 every cycle while the load is pending.
  - ld_valid, ld_rd=7 granted at cycle N → stall stays 1 through N+1 (regWrite to x7), then 0 at N+2.
  - hz_rs2=0 never stalls.
- x0 and simultaneous set/clear:
  - alu_rd=0 → accepted, regWrite stays 0.
  - Same cycle: ld_issue_rd=3 and a load grant with ld_rd=3 (bit already set) → pending[3] stays 1, sb_err stays 0.
- Reset mid-operation:
  - Pending bits set and a grant in cycle N; rst=0 at cycle N → N+1 shows regWrite=0, stall=0, sb_err=0.
  - After reset, rr favours the ALU on the first tie.
